// File: rtl/zbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zbus_pkg
// Purpose  : Shared types and constants for the Zorro II bus arbiter:
//            arbiter state encoding, HOST_MODE codes, default grant timeout.
// Revision : 1.0 - initial release
// ============================================================================
package zbus_pkg;

  // Arbiter state; BOOT runs once after reset, OFF/NODMA are terminal.
  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_OFF     = 3'd1,
    ST_NODMA   = 3'd2,
    ST_IDLE    = 3'd3,
    ST_REQ     = 3'd4,
    ST_GRANT   = 3'd5,
    ST_DMA     = 3'd6,
    ST_RELEASE = 3'd7
  } state_t;

  // HOST_MODE encodings reported to the rest of the card.
  localparam logic [1:0] c_HOST_OFF   = 2'd0;  // arbitration disabled
  localparam logic [1:0] c_HOST_A500  = 2'd1;  // A500 / A2000 rev 4
  localparam logic [1:0] c_HOST_B2000 = 2'd2;  // B2000, BOSS protocol
  localparam logic [1:0] c_HOST_NODMA = 2'd3;  // A500, DMA locked out

  // C7M cycles a granted master has to answer with BGACK_n.
  localparam int c_GRANT_TIMEOUT_DEFAULT = 15;

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff
// Purpose  : N-stage flip-flop synchronizer for active-low async inputs.
//            Reset presets every stage to 1 (the inactive level).
// Revision : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  generate
    if (STAGES == 1) begin : g_single
      // Single-stage capture of the asynchronous input.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 1'b1;
        else        r_sync <= i_d;
      end
    end else begin : g_chain
      // Shift the input through the synchronizer chain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '1;
        else        r_sync <= {r_sync[STAGES-2:0], i_d};
      end
    end
  endgenerate

  assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/zbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : zbus_arbiter
// Purpose  : Three-wire (BR/BG/BGACK) arbiter between the on-card 68SEC000
//            and Zorro II DMA masters. Detects host type once after reset,
//            then hands the bus to DMA masters once the CPU has let go.
// Revision : 1.0 - initial release
// ============================================================================
module zbus_arbiter
  import zbus_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int GRANT_TIMEOUT = c_GRANT_TIMEOUT_DEFAULT
) (
  input  logic       C7M,
  input  logic       RESET_n,
  input  logic       JP2,
  input  logic       BOSS_n_IN,
  input  logic       BG_n_IN,
  input  logic       BR_n_IN,
  input  logic       BGACK_n,
  input  logic       AS_CPU_n,
  input  logic       BG_68SEC000_n,
  output logic       BR_68SEC000_n,
  output logic       BR_n_OUT,
  output logic       BR_n_OE,
  output logic       BG_n_OUT,
  output logic       BG_n_OE,
  output logic       BOSS_n_OUT,
  output logic       BOSS_n_OE,
  output logic       E_OE,
  output logic       DMA_ACTIVE,
  output logic [1:0] HOST_MODE
);

  localparam logic [7:0] c_TIMEOUT = 8'(GRANT_TIMEOUT);

  logic       w_br_sync_n;
  logic       w_bgack_sync_n;

  state_t     r_state,     w_state_nxt;
  logic [7:0] r_cnt,       w_cnt_nxt;
  logic [7:0] w_cnt_inc;
  logic       r_br68,      w_br68_nxt;
  logic       r_br_oe,     w_br_oe_nxt;
  logic       r_bg_out,    w_bg_out_nxt;
  logic       r_bg_oe,     w_bg_oe_nxt;
  logic       r_boss_out,  w_boss_out_nxt;
  logic       r_boss_oe,   w_boss_oe_nxt;
  logic       r_e_oe,      w_e_oe_nxt;
  logic       r_dma,       w_dma_nxt;
  logic [1:0] r_host_mode, w_host_mode_nxt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_br (
    .clk   (C7M),
    .rst_n (RESET_n),
    .i_d   (BR_n_IN),
    .o_q   (w_br_sync_n)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_bgack (
    .clk   (C7M),
    .rst_n (RESET_n),
    .i_d   (BGACK_n),
    .o_q   (w_bgack_sync_n)
  );

  // Saturating grant counter increment; never wraps past the timeout.
  assign w_cnt_inc = (r_cnt < c_TIMEOUT) ? (r_cnt + 8'd1) : r_cnt;

  // Next-state and next-output decode; every register holds unless a state acts on it.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_br68_nxt      = r_br68;
    w_br_oe_nxt     = r_br_oe;
    w_bg_out_nxt    = r_bg_out;
    w_bg_oe_nxt     = r_bg_oe;
    w_boss_out_nxt  = r_boss_out;
    w_boss_oe_nxt   = r_boss_oe;
    w_e_oe_nxt      = r_e_oe;
    w_dma_nxt       = r_dma;
    w_host_mode_nxt = r_host_mode;

    case (r_state)
      ST_BOOT: begin
        if (!BG_n_IN && !JP2) begin
          // Another arbiter owns the bus: stay completely passive.
          w_state_nxt     = ST_OFF;
          w_host_mode_nxt = c_HOST_OFF;
        end else begin
          w_e_oe_nxt  = ~JP2;
          w_br_oe_nxt = 1'b0;
          w_br68_nxt  = 1'b1;
          if (BOSS_n_IN) begin
            w_host_mode_nxt = c_HOST_B2000;
            w_boss_out_nxt  = 1'b0;
            w_boss_oe_nxt   = 1'b1;
            w_state_nxt     = ST_IDLE;
          end else if (BG_n_IN) begin
            w_host_mode_nxt = c_HOST_A500;
            w_state_nxt     = ST_IDLE;
          end else begin
            w_host_mode_nxt = c_HOST_NODMA;
            w_state_nxt     = ST_NODMA;
          end
        end
      end

      ST_OFF, ST_NODMA: begin
        w_bg_oe_nxt = 1'b0;
      end

      ST_IDLE: begin
        w_bg_oe_nxt  = 1'b1;
        w_bg_out_nxt = 1'b1;
        w_cnt_nxt    = '0;
        // Request the CPU bus on the same edge the DMA request is seen.
        w_br68_nxt   = w_br_sync_n;
        if (!w_br_sync_n) w_state_nxt = ST_REQ;
      end

      ST_REQ: begin
        w_br68_nxt = 1'b0;
        w_cnt_nxt  = '0;
        if (!BG_68SEC000_n && AS_CPU_n) w_state_nxt = ST_GRANT;
        else if (w_br_sync_n)           w_state_nxt = ST_IDLE;
      end

      ST_GRANT: begin
        w_bg_out_nxt = 1'b0;
        w_br68_nxt   = 1'b0;
        w_cnt_nxt    = w_cnt_inc;
        if (!w_bgack_sync_n)
          w_state_nxt = ST_DMA;
        else if ((w_cnt_inc == c_TIMEOUT) && w_br_sync_n)
          w_state_nxt = ST_RELEASE;
      end

      ST_DMA: begin
        w_dma_nxt    = 1'b1;
        w_bg_out_nxt = 1'b1;
        w_br68_nxt   = 1'b0;
        if (w_bgack_sync_n) begin
          if (w_br_sync_n) begin
            w_state_nxt = ST_RELEASE;
          end else begin
            // Next master already waiting: regrant without returning the bus.
            w_state_nxt = ST_GRANT;
            w_cnt_nxt   = '0;
          end
        end
      end

      ST_RELEASE: begin
        w_br68_nxt  = 1'b1;
        w_dma_nxt   = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // State and registered outputs; async reset returns everything to boot values.
  always_ff @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state     <= ST_BOOT;
      r_cnt       <= '0;
      r_br68      <= 1'b0;
      r_br_oe     <= 1'b1;
      r_bg_out    <= 1'b1;
      r_bg_oe     <= 1'b0;
      r_boss_out  <= 1'b1;
      r_boss_oe   <= 1'b0;
      r_e_oe      <= 1'b0;
      r_dma       <= 1'b0;
      r_host_mode <= c_HOST_OFF;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_br68      <= w_br68_nxt;
      r_br_oe     <= w_br_oe_nxt;
      r_bg_out    <= w_bg_out_nxt;
      r_bg_oe     <= w_bg_oe_nxt;
      r_boss_out  <= w_boss_out_nxt;
      r_boss_oe   <= w_boss_oe_nxt;
      r_e_oe      <= w_e_oe_nxt;
      r_dma       <= w_dma_nxt;
      r_host_mode <= w_host_mode_nxt;
    end
  end

  // Motherboard BR is only ever pulled low; the enable alone controls it.
  assign BR_n_OUT      = 1'b0;
  assign BR_68SEC000_n = r_br68;
  assign BR_n_OE       = r_br_oe;
  assign BG_n_OUT      = r_bg_out;
  assign BG_n_OE       = r_bg_oe;
  assign BOSS_n_OUT    = r_boss_out;
  assign BOSS_n_OE     = r_boss_oe;
  assign E_OE          = r_e_oe;
  assign DMA_ACTIVE    = r_dma;
  assign HOST_MODE     = r_host_mode;

endmodule
`default_nettype wire

// File: tb/tb_zbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_zbus_arbiter
// Purpose  : Directed self-checking bench for zbus_arbiter: host detection,
//            request/grant/DMA/release, grant timeout, back-to-back masters
//            and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zbus_arbiter;

  logic       C7M = 1'b0;
  logic       RESET_n;
  logic       JP2, BOSS_n_IN, BG_n_IN, BR_n_IN, BGACK_n, AS_CPU_n, BG_68SEC000_n;
  logic       BR_68SEC000_n, BR_n_OUT, BR_n_OE, BG_n_OUT, BG_n_OE;
  logic       BOSS_n_OUT, BOSS_n_OE, E_OE, DMA_ACTIVE;
  logic [1:0] HOST_MODE;

  int errors = 0;
  int checks = 0;

  localparam int S_BR68 = 0, S_BROUT = 1, S_BROE = 2, S_BGOUT = 3, S_BGOE = 4;
  localparam int S_BOSSOUT = 5, S_BOSSOE = 6, S_EOE = 7, S_DMA = 8, S_HM = 9;

  typedef struct {
    string      tag;
    int         sig;
    logic [1:0] v;
  } exp_t;

  exp_t sb[$];

  zbus_arbiter #(.SYNC_STAGES(2), .GRANT_TIMEOUT(15)) dut (
    .C7M           (C7M),
    .RESET_n       (RESET_n),
    .JP2           (JP2),
    .BOSS_n_IN     (BOSS_n_IN),
    .BG_n_IN       (BG_n_IN),
    .BR_n_IN       (BR_n_IN),
    .BGACK_n       (BGACK_n),
    .AS_CPU_n      (AS_CPU_n),
    .BG_68SEC000_n (BG_68SEC000_n),
    .BR_68SEC000_n (BR_68SEC000_n),
    .BR_n_OUT      (BR_n_OUT),
    .BR_n_OE       (BR_n_OE),
    .BG_n_OUT      (BG_n_OUT),
    .BG_n_OE       (BG_n_OE),
    .BOSS_n_OUT    (BOSS_n_OUT),
    .BOSS_n_OE     (BOSS_n_OE),
    .E_OE          (E_OE),
    .DMA_ACTIVE    (DMA_ACTIVE),
    .HOST_MODE     (HOST_MODE)
  );

  always #5 C7M = ~C7M;

  function automatic logic [1:0] get_sig(input int sig);
    case (sig)
      S_BR68:    return {1'b0, BR_68SEC000_n};
      S_BROUT:   return {1'b0, BR_n_OUT};
      S_BROE:    return {1'b0, BR_n_OE};
      S_BGOUT:   return {1'b0, BG_n_OUT};
      S_BGOE:    return {1'b0, BG_n_OE};
      S_BOSSOUT: return {1'b0, BOSS_n_OUT};
      S_BOSSOE:  return {1'b0, BOSS_n_OE};
      S_EOE:     return {1'b0, E_OE};
      S_DMA:     return {1'b0, DMA_ACTIVE};
      default:   return HOST_MODE;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input logic [1:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.v   = v;
    sb.push_back(e);
  endtask

  // Pop every pending expectation and compare it with the live DUT output.
  task automatic check_sb();
    exp_t       e;
    logic [1:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = get_sig(e.sig);
      checks++;
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge C7M);
    #1;
  endtask

  task automatic expect_reset_vals(input string tag);
    expect_val({tag, ".br68"},    S_BR68,    2'd0);
    expect_val({tag, ".brout"},   S_BROUT,   2'd0);
    expect_val({tag, ".broe"},    S_BROE,    2'd1);
    expect_val({tag, ".bgout"},   S_BGOUT,   2'd1);
    expect_val({tag, ".bgoe"},    S_BGOE,    2'd0);
    expect_val({tag, ".bossout"}, S_BOSSOUT, 2'd1);
    expect_val({tag, ".bossoe"},  S_BOSSOE,  2'd0);
    expect_val({tag, ".eoe"},     S_EOE,     2'd0);
    expect_val({tag, ".dma"},     S_DMA,     2'd0);
    expect_val({tag, ".hm"},      S_HM,      2'd0);
    check_sb();
  endtask

  // Hold reset with the given bootstrap pins, check reset values, release.
  task automatic boot(input logic boss, input logic bg, input logic jp2, input string tag);
    RESET_n = 1'b0;
    BOSS_n_IN = boss; BG_n_IN = bg; JP2 = jp2;
    BR_n_IN = 1'b1; BGACK_n = 1'b1; AS_CPU_n = 1'b1; BG_68SEC000_n = 1'b1;
    tick(2);
    expect_reset_vals({tag, ".rst"});
    RESET_n = 1'b1;
    tick(1);
  endtask

  initial begin
    RESET_n = 1'b0;
    JP2 = 1'b0; BOSS_n_IN = 1'b0; BG_n_IN = 1'b1; BR_n_IN = 1'b1;
    BGACK_n = 1'b1; AS_CPU_n = 1'b1; BG_68SEC000_n = 1'b1;
    tick(1);

    // Disabled host: BG low, JP2 low -> OFF, nothing moves for 100 cycles.
    boot(1'b0, 1'b0, 1'b0, "off");
    expect_reset_vals("off.boot");
    BR_n_IN = 1'b0; BGACK_n = 1'b0; BG_68SEC000_n = 1'b0;
    tick(100);
    expect_reset_vals("off.hold");

    // A500 with DMA locked out: NODMA ignores requests.
    boot(1'b0, 1'b0, 1'b1, "nodma");
    expect_val("nodma.hm", S_HM, 2'd3);
    expect_val("nodma.br68", S_BR68, 2'd1);
    expect_val("nodma.eoe", S_EOE, 2'd0);
    expect_val("nodma.broe", S_BROE, 2'd0);
    check_sb();
    BR_n_IN = 1'b0;
    tick(10);
    expect_val("nodma.hold.br68", S_BR68, 2'd1);
    expect_val("nodma.hold.bgoe", S_BGOE, 2'd0);
    check_sb();

    // B2000 host.
    boot(1'b1, 1'b1, 1'b0, "b2000");
    expect_val("b2000.hm", S_HM, 2'd2);
    expect_val("b2000.bossoe", S_BOSSOE, 2'd1);
    expect_val("b2000.bossout", S_BOSSOUT, 2'd0);
    expect_val("b2000.eoe", S_EOE, 2'd1);
    expect_val("b2000.br68", S_BR68, 2'd1);
    expect_val("b2000.broe", S_BROE, 2'd0);
    check_sb();
    tick(1);
    expect_val("b2000.idle.bgoe", S_BGOE, 2'd1);
    expect_val("b2000.idle.bgout", S_BGOUT, 2'd1);
    check_sb();

    // A500/A2000r4 host with JP2=1 (no local E clock), then a full DMA cycle.
    boot(1'b0, 1'b1, 1'b1, "a500");
    expect_val("a500.hm", S_HM, 2'd1);
    expect_val("a500.eoe", S_EOE, 2'd0);
    expect_val("a500.bossoe", S_BOSSOE, 2'd0);
    check_sb();
    tick(1);
    BR_n_IN = 1'b0;
    tick(2);
    expect_val("dma.br68.e2", S_BR68, 2'd1);
    check_sb();
    tick(1);
    expect_val("dma.br68.e3", S_BR68, 2'd0);
    check_sb();
    BG_68SEC000_n = 1'b0; AS_CPU_n = 1'b1;
    tick(1);
    expect_val("dma.bgout.e1", S_BGOUT, 2'd1);
    check_sb();
    tick(1);
    expect_val("dma.bgout.e2", S_BGOUT, 2'd0);
    check_sb();
    BGACK_n = 1'b0;
    tick(3);
    expect_val("dma.ack.e3.bgout", S_BGOUT, 2'd0);
    expect_val("dma.ack.e3.dma", S_DMA, 2'd0);
    check_sb();
    tick(1);
    expect_val("dma.ack.e4.dma", S_DMA, 2'd1);
    expect_val("dma.ack.e4.bgout", S_BGOUT, 2'd1);
    expect_val("dma.ack.e4.br68", S_BR68, 2'd0);
    check_sb();
    BR_n_IN = 1'b1;
    tick(5);
    expect_val("dma.hold.dma", S_DMA, 2'd1);
    expect_val("dma.hold.br68", S_BR68, 2'd0);
    check_sb();
    BGACK_n = 1'b1;
    tick(3);
    expect_val("rel.e3.br68", S_BR68, 2'd0);
    expect_val("rel.e3.dma", S_DMA, 2'd1);
    check_sb();
    tick(1);
    expect_val("rel.e4.br68", S_BR68, 2'd1);
    expect_val("rel.e4.dma", S_DMA, 2'd0);
    check_sb();

    // Grant timeout: request withdrawn in GRANT, BGACK never arrives.
    BR_n_IN = 1'b0;
    tick(3);
    expect_val("to.req.br68", S_BR68, 2'd0);
    check_sb();
    tick(1);                       // GRANT entered on this edge
    BR_n_IN = 1'b1;
    tick(14);
    expect_val("to.e14.br68", S_BR68, 2'd0);
    expect_val("to.e14.bgout", S_BGOUT, 2'd0);
    check_sb();
    tick(1);
    expect_val("to.e15.br68", S_BR68, 2'd0);
    check_sb();
    tick(1);
    expect_val("to.e16.br68", S_BR68, 2'd1);
    check_sb();
    tick(1);
    expect_val("to.idle.bgout", S_BGOUT, 2'd1);
    check_sb();

    // Counter saturation: request held well past the timeout stays in GRANT.
    BR_n_IN = 1'b0;
    tick(4);
    tick(40);
    expect_val("sat.bgout", S_BGOUT, 2'd0);
    expect_val("sat.br68", S_BR68, 2'd0);
    expect_val("sat.dma", S_DMA, 2'd0);
    check_sb();
    BR_n_IN = 1'b1;
    tick(3);
    expect_val("sat.rel.e3.br68", S_BR68, 2'd0);
    check_sb();
    tick(1);
    expect_val("sat.rel.e4.br68", S_BR68, 2'd1);
    check_sb();

    // Back-to-back masters: BGACK release with a new request within the cycle.
    BR_n_IN = 1'b0;
    tick(4);
    BGACK_n = 1'b0;
    tick(4);
    expect_val("b2b.dma", S_DMA, 2'd1);
    check_sb();
    BGACK_n = 1'b1; BR_n_IN = 1'b1;
    #2;
    BR_n_IN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      expect_val("b2b.br68", S_BR68, 2'd0);
      check_sb();
    end
    expect_val("b2b.regrant.bgout", S_BGOUT, 2'd0);
    check_sb();
    BGACK_n = 1'b0;
    tick(4);
    expect_val("b2b.dma2.dma", S_DMA, 2'd1);
    expect_val("b2b.dma2.bgout", S_BGOUT, 2'd1);
    check_sb();

    // Asynchronous reset in the middle of DMA, then BOOT runs again.
    RESET_n = 1'b0;
    BOSS_n_IN = 1'b1; BG_n_IN = 1'b1; JP2 = 1'b0;
    #2;
    expect_reset_vals("arst");
    tick(1);
    BR_n_IN = 1'b1; BGACK_n = 1'b1; BG_68SEC000_n = 1'b1;
    RESET_n = 1'b1;
    tick(1);
    expect_val("reboot.hm", S_HM, 2'd2);
    expect_val("reboot.br68", S_BR68, 2'd1);
    expect_val("reboot.bossoe", S_BOSSOE, 2'd1);
    check_sb();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
